// File: rtl/cfo_pkg.sv
// Shared definitions for the CFO estimation datapath: sample width and the
// load-driver burst state machine encoding.
package cfo_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

endpackage

// File: rtl/iq_load_driver_if.sv
// Write, burst-control and paced-output signals of iq_load_driver.
// The master side feeds samples and starts bursts; the slave side is the driver.
interface iq_load_driver_if
  import cfo_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [W-1:0]  wr_r;
  logic [W-1:0]  wr_i;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
  logic          start;
  logic [AW:0]   burst_len;
  logic          busy;
  logic          done;
  logic [W-1:0]  out_r;
  logic [W-1:0]  out_i;
  logic          ld_out;

  modport master (
    output wr_en, wr_r, wr_i, start, burst_len,
    input  full, level, overflow, busy, done, out_r, out_i, ld_out
  );

  modport slave (
    input  wr_en, wr_r, wr_i, start, burst_len,
    output full, level, overflow, busy, done, out_r, out_i, ld_out
  );

endinterface

// File: rtl/iq_fifo.sv
// Synchronous FIFO of I/Q words with registered pointers and occupancy.
// The head word is read combinationally so a pop decision sees it in the same cycle.
module iq_fifo #(
  parameter  int DW    = 48,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_head,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Fullness is judged on start-of-cycle occupancy, so a simultaneous pop
  // never makes room for a write in the same cycle.
  assign o_full    = (r_level == LEVEL_FULL);
  assign o_empty   = (r_level == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LEVEL_ONE;
        2'b01:   r_level <= r_level - LEVEL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/iq_load_driver.sv
// Paced I/Q burst transmitter: pops a programmed number of samples from the
// internal FIFO and presents each with a one-cycle load strobe, >= PACE cycles apart.
module iq_load_driver
  import cfo_pkg::*;
#(
  parameter  int W     = SAMPLE_W,
  parameter  int DEPTH = 16,
  parameter  int PACE  = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst,
  iq_load_driver_if.slave io_bus
);

  localparam int          PW          = $clog2(PACE + 1);
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);
  localparam logic [PW-1:0] PACE_ONE    = PW'(1);
  localparam logic [AW:0]   REM_ONE     = (AW+1)'(1);

  state_t          r_state;
  logic [AW:0]     r_remaining;
  logic [PW-1:0]   r_pace;
  logic [W-1:0]    r_out_r;
  logic [W-1:0]    r_out_i;
  logic            r_ld_out;
  logic            r_done;
  logic            r_busy;
  logic            r_overflow;

  logic [2*W-1:0]  w_head;
  logic [AW:0]     w_level;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;

  // An underrun simply leaves w_pop low with the pace counter parked at zero.
  assign w_pop = (r_state == RUN) && (r_pace == '0) && !w_empty;

  iq_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (io_bus.wr_en),
    .i_pop   (w_pop),
    .i_data  ({io_bus.wr_r, io_bus.wr_i}),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_pace      <= '0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_ld_out    <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_ld_out <= 1'b0;
      r_done   <= 1'b0;
      if (io_bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (io_bus.start && (io_bus.burst_len != '0)) begin
            r_remaining <= io_bus.burst_len;
            r_pace      <= '0;
            r_busy      <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (r_pace != '0) begin
            r_pace <= r_pace - PACE_ONE;
          end else if (w_pop) begin
            r_out_r     <= w_head[2*W-1:W];
            r_out_i     <= w_head[W-1:0];
            r_ld_out    <= 1'b1;
            r_pace      <= PACE_RELOAD;
            r_remaining <= r_remaining - REM_ONE;
            // The final strobe and done are raised together for the LAST cycle.
            if (r_remaining == REM_ONE) begin
              r_done  <= 1'b1;
              r_state <= LAST;
            end
          end
        end
        LAST: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.full     = w_full;
  assign io_bus.level    = w_level;
  assign io_bus.overflow = r_overflow;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.out_r    = r_out_r;
  assign io_bus.out_i    = r_out_i;
  assign io_bus.ld_out   = r_ld_out;

endmodule
